// File: rtl/uart_dma_if.sv
// Signal bundle between the UART DMA engine, the UART receiver/transmitter and the hub.
// The master modport is the DMA engine's view; the slave modport is its surroundings.
interface uart_dma_if;
    logic        rx_valid;
    logic [7:0]  rdata;
    logic        rx_ferr;
    logic        instr_ready;
    logic        mem_ready;
    logic [31:0] data;
    logic        program_loaded;
    logic        tx_start;
    logic [7:0]  sdata;
    logic        tx_busy;
    logic [7:0]  err_count;

    modport master (
        input  rx_valid, rdata, rx_ferr, tx_busy,
        output instr_ready, mem_ready, data, program_loaded, tx_start, sdata, err_count
    );

    modport slave (
        output rx_valid, rdata, rx_ferr, tx_busy,
        input  instr_ready, mem_ready, data, program_loaded, tx_start, sdata, err_count
    );
endinterface

// File: rtl/uart_dma_controller.sv
// Receive-side DMA: packs UART bytes into little-endian words, boot-loads a length-prefixed
// program, acknowledges it over the shared transmitter, then streams data words to the hub.
module uart_dma_controller #(
    parameter int unsigned MAX_INSTR_WORDS = 256,
    parameter logic [7:0]  ACK_BYTE        = 8'h99
) (
    input logic       clock,
    input logic       reset,
    uart_dma_if.master bus
);

    typedef enum logic [2:0] {StWaitLen, StLoad, StSendAck, StAckDrain, StRun} state_e;

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] len_q, len_d;
    logic [31:0] data_q, data_d;
    logic        instr_q, instr_d;
    logic        mem_q, mem_d;
    logic        loaded_q, loaded_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  sdata_q, sdata_d;
    logic [7:0]  err_q, err_d;
    logic        drain_first_q, drain_first_d;

    logic        in_ack;
    logic        byte_ok;
    logic        byte_err;
    logic        word_done;
    logic [31:0] word;

    assign in_ack    = (state_q == StSendAck) || (state_q == StAckDrain);
    assign byte_ok   = bus.rx_valid && !bus.rx_ferr && !in_ack;
    // Bytes arriving while the ack is in flight are dropped and counted like framing errors.
    assign byte_err  = bus.rx_valid && (bus.rx_ferr || in_ack);
    assign word_done = byte_ok && (byte_cnt_q == 2'd3);
    assign word      = {bus.rdata, shift_q};

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        shift_d       = shift_q;
        word_cnt_d    = word_cnt_q;
        len_d         = len_q;
        data_d        = data_q;
        instr_d       = 1'b0;
        mem_d         = 1'b0;
        loaded_d      = loaded_q;
        tx_start_d    = 1'b0;
        sdata_d       = sdata_q;
        err_d         = err_q;
        drain_first_d = drain_first_q;

        if (byte_err && (err_q != 8'hff)) begin
            err_d = err_q + 8'd1;
        end
        if (bus.rx_valid && bus.rx_ferr && !in_ack) begin
            byte_cnt_d = 2'd0;
        end

        if (byte_ok) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    shift_d[7:0]   = bus.rdata;
                2'd1:    shift_d[15:8]  = bus.rdata;
                2'd2:    shift_d[23:16] = bus.rdata;
                default: ;
            endcase
        end

        case (state_q)
            StWaitLen: begin
                if (word_done) begin
                    len_d      = word;
                    word_cnt_d = 32'd0;
                    state_d    = (word == 32'd0) ? StSendAck : StLoad;
                end
            end
            StLoad: begin
                if (word_done) begin
                    word_cnt_d = word_cnt_q + 32'd1;
                    // Words past the code segment are consumed silently.
                    if (word_cnt_q < MAX_INSTR_WORDS) begin
                        instr_d = 1'b1;
                        data_d  = word;
                    end
                    if ((word_cnt_q + 32'd1) == len_q) begin
                        state_d = StSendAck;
                    end
                end
            end
            StSendAck: begin
                if (!bus.tx_busy) begin
                    tx_start_d    = 1'b1;
                    sdata_d       = ACK_BYTE;
                    drain_first_d = 1'b1;
                    state_d       = StAckDrain;
                end
            end
            StAckDrain: begin
                // The transmitter raises busy one cycle after start, so skip that cycle.
                if (drain_first_q) begin
                    drain_first_d = 1'b0;
                end else if (!bus.tx_busy) begin
                    state_d  = StRun;
                    loaded_d = 1'b1;
                end
            end
            StRun: begin
                if (word_done) begin
                    mem_d  = 1'b1;
                    data_d = word;
                end
            end
            default: state_d = StWaitLen;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StWaitLen;
            byte_cnt_q    <= 2'd0;
            shift_q       <= 24'd0;
            word_cnt_q    <= 32'd0;
            len_q         <= 32'd0;
            data_q        <= 32'd0;
            instr_q       <= 1'b0;
            mem_q         <= 1'b0;
            loaded_q      <= 1'b0;
            tx_start_q    <= 1'b0;
            sdata_q       <= 8'd0;
            err_q         <= 8'd0;
            drain_first_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            shift_q       <= shift_d;
            word_cnt_q    <= word_cnt_d;
            len_q         <= len_d;
            data_q        <= data_d;
            instr_q       <= instr_d;
            mem_q         <= mem_d;
            loaded_q      <= loaded_d;
            tx_start_q    <= tx_start_d;
            sdata_q       <= sdata_d;
            err_q         <= err_d;
            drain_first_q <= drain_first_d;
        end
    end

    assign bus.instr_ready    = instr_q;
    assign bus.mem_ready      = mem_q;
    assign bus.data           = data_q;
    assign bus.program_loaded = loaded_q;
    assign bus.tx_start       = tx_start_q;
    assign bus.sdata          = sdata_q;
    assign bus.err_count      = err_q;

endmodule

// File: tb/tb_uart_dma_controller.sv
// Directed bench for uart_dma_controller: a scoreboard queue holds expected strobes (kind,
// word, cycle) pushed as the 4th byte is driven and popped by a negedge monitor.
module tb_uart_dma_controller;

    logic clock;
    logic reset;
    uart_dma_if bus ();

    uart_dma_controller #(
        .MAX_INSTR_WORDS(4),
        .ACK_BYTE       (8'h99)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit          instr;
        logic [31:0] word;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          tx_pulses = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard, in kind, data and cycle.
    always @(negedge clock) begin
        if (bus.instr_ready || bus.mem_ready) begin
            check("strobe_exclusive", {31'd0, bus.instr_ready && bus.mem_ready}, 32'd0);
            check("strobe_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_kind", {31'd0, bus.instr_ready}, {31'd0, e.instr});
                check("strobe_data", bus.data, e.word);
                check("strobe_cycle", cyc, e.due);
            end
        end
        if (bus.tx_start) begin
            tx_pulses++;
            check("ack_sdata", {24'd0, bus.sdata}, 32'h99);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic ferr);
        bus.rx_valid = 1'b1;
        bus.rdata    = b;
        bus.rx_ferr  = ferr;
        @(posedge clock);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_ferr  = 1'b0;
    endtask

    // kind: 0 = no strobe expected, 1 = instr_ready, 2 = mem_ready
    task automatic send_word(input logic [31:0] w, input int kind);
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && kind != 0) begin
                exp_t e;
                e.instr = (kind == 1);
                e.word  = w;
                e.due   = cyc + 1;
                sb.push_back(e);
            end
            send_byte(w[8*i +: 8], 1'b0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_instr_ready"}, {31'd0, bus.instr_ready}, 32'd0);
        check({tag, "_mem_ready"}, {31'd0, bus.mem_ready}, 32'd0);
        check({tag, "_data"}, bus.data, 32'd0);
        check({tag, "_program_loaded"}, {31'd0, bus.program_loaded}, 32'd0);
        check({tag, "_tx_start"}, {31'd0, bus.tx_start}, 32'd0);
        check({tag, "_sdata"}, {24'd0, bus.sdata}, 32'd0);
        check({tag, "_err_count"}, {24'd0, bus.err_count}, 32'd0);
    endtask

    task automatic wait_loaded(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (bus.program_loaded) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, seen}, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic settle_and_check_empty(input string tag);
        repeat (3) @(negedge clock);
        check(tag, sb.size(), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit seen;
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rdata    = 8'd0;
        bus.rx_ferr  = 1'b0;
        bus.tx_busy  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_zero_outputs("reset");
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Boot N=2 with a stalled transmitter around the ack.
        send_word(32'd2, 0);
        send_word(32'h44332211, 1);
        bus.tx_busy = 1'b1;
        send_word(32'hDDCCBBAA, 1);
        repeat (5) begin
            @(negedge clock);
            check("tx_start_withheld", {31'd0, bus.tx_start}, 32'd0);
        end
        bus.tx_busy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (bus.tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        check("ack_pulse_seen", {31'd0, seen}, 32'd1);
        bus.tx_busy = 1'b1;
        repeat (10) begin
            @(negedge clock);
            check("loaded_while_busy", {31'd0, bus.program_loaded}, 32'd0);
        end
        bus.tx_busy = 1'b0;
        wait_loaded("boot_loaded", 6);
        check("boot_ack_count", tx_pulses, 32'd1);
        check("boot_sb_empty", sb.size(), 32'd0);

        // Framing error in RUN resyncs the byte counter.
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        send_word(32'h40302010, 2);
        settle_and_check_empty("ferr_sb_empty");
        check("ferr_err_count", {24'd0, bus.err_count}, 32'd1);

        // Overflow: N=6 with a 4-word code segment.
        apply_reset();
        check("ovf_err_cleared", {24'd0, bus.err_count}, 32'd0);
        send_word(32'd6, 0);
        for (int i = 0; i < 6; i++) begin
            send_word(32'h1000_0000 + 32'(i), (i < 4) ? 1 : 0);
        end
        wait_loaded("ovf_loaded", 10);
        check("ovf_ack_count", tx_pulses, 32'd2);
        settle_and_check_empty("ovf_sb_empty");

        // Asynchronous reset between the 2nd and 3rd byte of an instruction word.
        apply_reset();
        send_word(32'd2, 0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_zero_outputs("midload");
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        send_word(32'd1, 0);
        send_word(32'hCAFEBABE, 1);
        wait_loaded("midload_loaded", 10);
        check("midload_ack_count", tx_pulses, 32'd3);
        settle_and_check_empty("midload_sb_empty");

        // N=0: straight to ack, then data words go to mem_ready.
        apply_reset();
        send_word(32'd0, 0);
        wait_loaded("n0_loaded", 10);
        check("n0_ack_count", tx_pulses, 32'd4);
        send_word(32'h00000001, 2);
        settle_and_check_empty("n0_sb_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_dma_controller.md
Name: uart_dma_controller

Overview:
- Receive-side DMA engine between the UART receiver and the memory controller hub.
- Assembles received UART bytes into 32-bit little-endian words and drives the hub's DMA inputs: `instr_ready` during boot, `mem_ready` afterwards.
- At boot it loads a length-prefixed program, sends one acknowledge byte through the shared UART transmitter, then raises `program_loaded`.
- It uses the UART transmitter only before `program_loaded`; the hub uses it only after, so the two never overlap.

Parameters:
- MAX_INSTR_WORDS, 256: capacity of the code segment in words. Instruction words beyond this are consumed but not written.
- ACK_BYTE, 8'h99: byte sent to the host once the program is fully received.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (reset asserted when low).
- rx_valid  input  1  one-cycle strobe from the UART receiver: `rdata` is valid.
- rdata  input  8  received byte.
- rx_ferr  input  1  framing error flag, sampled together with `rx_valid`.
- instr_ready  output  1  one-cycle strobe: `data` holds an instruction word.
- mem_ready  output  1  one-cycle strobe: `data` holds an input-data word.
- data  output  32  assembled word; held until the next word completes.
- program_loaded  output  1  level; high once boot is complete.
- tx_start  output  1  one-cycle start pulse to the UART transmitter.
- sdata  output  8  byte to transmit.
- tx_busy  input  1  UART transmitter busy.
- err_count  output  8  saturating count of framing errors.

Behaviour:
- Reset (asynchronous, while `reset` is low):
  - All outputs go to 0: `instr_ready`, `mem_ready`, `data`, `program_loaded`, `tx_start`, `sdata`, `err_count`.
  - State goes to WAIT_LEN; byte counter, word counter and shift register clear.
  - Reset mid-load or mid-ack aborts the operation; no partial word is ever emitted.
- Byte assembly (all states except SEND_ACK and ACK_DRAIN):
  - A 2-bit byte counter tracks position. The byte received with counter k goes to bits [8k+7:8k], so the first byte is the LSB.
  - On the 4th byte (counter == 3), the word is registered into `data` on the same edge as its strobe.
  - Latency: strobe is high in the cycle after the 4th `rx_valid`, for exactly one cycle.
- Framing errors:
  - `rx_valid` with `rx_ferr` high: the byte is discarded, the byte counter returns to 0 (resync), and `err_count` increments, saturating at 255.
  - No strobe is produced for that byte.
- `rx_valid` arriving during SEND_ACK or ACK_DRAIN is dropped and counted as an error. The host must wait for the ack before sending.
- State machine:
  - WAIT_LEN: the first word is the instruction count N and is not strobed. N == 0 goes to SEND_ACK; otherwise go to LOAD.
  - LOAD: each word increments a 32-bit word counter.
    - If counter < MAX_INSTR_WORDS, pulse `instr_ready` with the word; otherwise no strobe.
    - When counter reaches N, go to SEND_ACK. The final strobe and the transition happen on the same edge.
  - SEND_ACK: wait for `tx_busy` low. Then, for one cycle, pulse `tx_start` with `sdata` = ACK_BYTE; go to ACK_DRAIN.
  - ACK_DRAIN: ignore `tx_busy` in the first cycle after the pulse (the transmitter raises busy one cycle late). Thereafter, when `tx_busy` is low, go to RUN.
  - RUN: set `program_loaded` = 1, held until reset. Every assembled word pulses `mem_ready`. `tx_start` stays 0 and `sdata` holds its last value.
- `instr_ready` and `mem_ready` are never high in the same cycle.
- At most one strobe every 4 `rx_valid` events. Back-to-back `rx_valid` on consecutive cycles must be accepted.

Test Plan:
- Boot with N=2: bytes 02 00 00 00, then 11 22 33 44 and AA BB CC DD. Expect exactly two `instr_ready` pulses with `data` = 0x44332211 and then 0xDDCCBBAA, one cycle after each 4th byte; no `mem_ready`.
- Ack handshake: after the last instruction byte, with `tx_busy` high for 5 cycles, `tx_start` is withheld. It pulses once with `sdata` = 0x99 when busy drops. Then hold `tx_busy` high for 10 cycles from the next cycle; `program_loaded` rises only after it falls.
- N=0: bytes 00 00 00 00 produce no `instr_ready`, the ack is sent, and `program_loaded` = 1. Next bytes 01 00 00 00 produce `mem_ready` with `data` = 0x00000001.
- Overflow: with MAX_INSTR_WORDS=4, N=6 gives 4 `instr_ready` pulses, 2 silent words, then the ack.
- Framing error: in RUN, send bytes 01 02, then 03 with `rx_ferr`, then 10 20 30 40. Expect `err_count` = 1 and one `mem_ready` with 0x40302010.
- Asynchronous reset asserted between the 2nd and 3rd byte of an instruction word: all outputs go to 0 immediately. After release, a new length word is required and no stale word appears.
